regfile_write_arbiter: RTL
==========================

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 4; register address width.
REQ-002 Parameter DATA_WIDTH, default 32; data width.
REQ-003 Parameter STARVE_LIMIT, default 4; number of consecutive A-over-B wins before B is forced.
REQ-004 CLK  in  1  the single clock, rising-edge active.
REQ-005 RST_N  in  1  asynchronous, active-low reset.
REQ-006 A_VALID / A_ADDR / A_DATA  in  1 / ADDR_WIDTH / DATA_WIDTH  requester A (ALU writeback) write request.
REQ-007 A_READY  out  1  A request accepted this cycle.
REQ-008 B_VALID / B_ADDR / B_DATA  in  1 / ADDR_WIDTH / DATA_WIDTH  requester B (load writeback) write request.
REQ-009 B_READY  out  1  B request accepted this cycle.
REQ-010 RW / PW / LE  out  ADDR_WIDTH / DATA_WIDTH / 1  register-file write port: address, data, load enable.
REQ-011 PC_LOAD / PC_VALUE  out  1 / DATA_WIDTH  redirect pulse and target for writes to R15.

Function
REQ-012 A handshake occurs when VALID and READY are both high at a rising CLK edge; the requester holds VALID, ADDR and DATA stable until that edge.
REQ-013 READY is combinational from the VALID inputs and the starvation state; at most one of A_READY and B_READY is high in any cycle.
REQ-014 Default priority: A wins whenever A_VALID=1; B_READY = B_VALID and not A_VALID.
REQ-015 Latency: a request accepted at edge N drives RW/PW/LE (or PC_LOAD/PC_VALUE) for exactly the cycle after edge N; the register file commits it at edge N+1.
REQ-016 FSM states: ST_IDLE (LE=0, PC_LOAD=0), ST_WRITE (LE=1), ST_PC (PC_LOAD=1). Each edge moves to ST_WRITE on an accepted address other than 15, ST_PC on an accepted address of 15, and ST_IDLE otherwise; back-to-back grants every cycle are allowed.
REQ-017 An accepted address of 15 is never written to the register file: LE=0, PC_LOAD=1, PC_VALUE=accepted data.
REQ-018 RW/PW hold their last values while in ST_IDLE; PC_VALUE holds its last value while PC_LOAD=0.
REQ-019 Both requesters valid with equal addresses: the grant follows REQ-014/REQ-022, and the loser writes on a later cycle (last writer wins).
REQ-020 No buffering: a requester that is not granted keeps waiting, and no request is dropped or duplicated.

Reset
REQ-021 RST_N low immediately forces state ST_IDLE, LE=0, PC_LOAD=0, RW=0, PW=0, PC_VALUE=0 and starvation count 0; a write or redirect in flight is discarded; normal operation resumes at the first edge after RST_N rises.

Configuration
REQ-022 With REGWR_ARB_STARVE_EN defined: the counter increments at each edge where A is granted while B_VALID=1; it clears on a B grant or when B_VALID=0. When count == STARVE_LIMIT and B_VALID=1, B_READY=1 and A_READY=0.
REQ-023 Without REGWR_ARB_STARVE_EN: strict A priority, no counter logic is present, and B may starve indefinitely.

Structure
REQ-024 Package regfile_pkg holds ADDR_WIDTH, DATA_WIDTH, PC_REG_ADDR=15 and the FSM state enum (ST_IDLE, ST_WRITE, ST_PC).
REQ-025 The starvation counter is sub-module regwr_starve_ctr, instantiated only under REGWR_ARB_STARVE_EN.

Verification
REQ-026 A only: A_ADDR=3, A_DATA=20 for one edge -> next cycle LE=1, RW=3, PW=20; the following cycle LE=0.
REQ-027 Simultaneous: A(2,21) and B(5,99) -> A_READY=1, B_READY=0; next cycle RW=2; B granted the following cycle, then RW=5, PW=99.
REQ-028 R15 write: B(15,0x100) alone -> next cycle PC_LOAD=1, PC_VALUE=0x100, LE=0.
REQ-029 Starvation (macro on, STARVE_LIMIT=4): A and B valid continuously -> A wins 4 edges, B wins the 5th, then A again. With the macro off, B is never granted.
REQ-030 Reset mid-operation: RST_N low in the cycle LE=1 -> LE=0 and RW=0 immediately, without waiting for a clock edge. After release, A(1,7) produces LE=1, RW=1 one cycle later.
REQ-031 Back-to-back: A valid with addresses 0..14 on consecutive edges -> LE=1 for 15 consecutive cycles with RW=0..14 in order.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared widths, the R15 redirect address and FSM state encoding for the
// register-file write arbiter.
package regfile_pkg;

  localparam int ADDR_WIDTH  = 4;
  localparam int DATA_WIDTH  = 32;
  localparam int PC_REG_ADDR = 15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_PC    = 2'd2
  } state_t;

endpackage

// File: rtl/regwr_starve_ctr.sv
// Counts consecutive A wins while B is waiting; requests a forced B grant
// once the count reaches STARVE_LIMIT. Used only with REGWR_ARB_STARVE_EN.
module regwr_starve_ctr #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic i_a_grant,
  input  logic i_b_valid,
  input  logic i_b_grant,
  output logic o_force_b
);
  import regfile_pkg::*;

  localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] r_cnt;

  // Never exceeds LIMIT: reaching it forces a B grant, which clears it.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cnt <= '0;
    end else if (i_a_grant && i_b_valid) begin
      r_cnt <= r_cnt + 1'b1;
    end else if (i_b_grant || !i_b_valid) begin
      r_cnt <= '0;
    end
  end

  assign o_force_b = i_b_valid && (r_cnt == LIMIT);

endmodule

// File: rtl/regfile_write_arbiter.sv
// Two-requester register-file write arbiter (A = ALU, B = load) with an R15
// redirect path. Define REGWR_ARB_STARVE_EN to enable B anti-starvation.
module regfile_write_arbiter #(
  parameter int ADDR_WIDTH   = regfile_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH   = regfile_pkg::DATA_WIDTH,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  A_VALID,
  input  logic [ADDR_WIDTH-1:0] A_ADDR,
  input  logic [DATA_WIDTH-1:0] A_DATA,
  output logic                  A_READY,
  input  logic                  B_VALID,
  input  logic [ADDR_WIDTH-1:0] B_ADDR,
  input  logic [DATA_WIDTH-1:0] B_DATA,
  output logic                  B_READY,
  output logic [ADDR_WIDTH-1:0] RW,
  output logic [DATA_WIDTH-1:0] PW,
  output logic                  LE,
  output logic                  PC_LOAD,
  output logic [DATA_WIDTH-1:0] PC_VALUE
);
  import regfile_pkg::*;

  localparam logic [ADDR_WIDTH-1:0] PC_ADDR = ADDR_WIDTH'(PC_REG_ADDR);

  state_t                r_state;
  state_t                w_next_state;
  logic [ADDR_WIDTH-1:0] r_rw;
  logic [DATA_WIDTH-1:0] r_pw;
  logic [DATA_WIDTH-1:0] r_pc_value;

  logic                  w_force_b;
  logic                  w_a_grant;
  logic                  w_b_grant;
  logic                  w_any_grant;
  logic                  w_is_pc;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_data;

`ifdef REGWR_ARB_STARVE_EN
  regwr_starve_ctr #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve_ctr (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .i_a_grant (w_a_grant),
    .i_b_valid (B_VALID),
    .i_b_grant (w_b_grant),
    .o_force_b (w_force_b)
  );
`else
  assign w_force_b = 1'b0;
`endif

  // A has priority unless B has been starved long enough to be forced.
  assign A_READY = A_VALID & ~w_force_b;
  assign B_READY = B_VALID & (~A_VALID | w_force_b);

  assign w_a_grant   = A_READY;
  assign w_b_grant   = B_READY;
  assign w_any_grant = w_a_grant | w_b_grant;
  assign w_sel_addr  = w_a_grant ? A_ADDR : B_ADDR;
  assign w_sel_data  = w_a_grant ? A_DATA : B_DATA;
  assign w_is_pc     = (w_sel_addr == PC_ADDR);

  always_comb begin
    w_next_state = ST_IDLE;
    if (w_any_grant) begin
      w_next_state = w_is_pc ? ST_PC : ST_WRITE;
    end
  end

  // Accepted request is presented for exactly one cycle; R15 goes to the PC path.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= ST_IDLE;
      r_rw       <= '0;
      r_pw       <= '0;
      r_pc_value <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_any_grant && !w_is_pc) begin
        r_rw <= w_sel_addr;
        r_pw <= w_sel_data;
      end
      if (w_any_grant && w_is_pc) begin
        r_pc_value <= w_sel_data;
      end
    end
  end

  assign LE       = (r_state == ST_WRITE);
  assign PC_LOAD  = (r_state == ST_PC);
  assign RW       = r_rw;
  assign PW       = r_pw;
  assign PC_VALUE = r_pc_value;

endmodule
